// File: rtl/sum_sq_accumulator.sv
//-----------------------------------------------------------------------------
// sum_sq_accumulator
//
// Purpose:
//    Squares each incoming ADC sample and sums the squares over a window of
//    N = 2**BUF_BIT_W valid samples. This block feeds the RMS square-root
//    stage. Windows run back to back, so no sample is dropped between them.
//    Each closed window produces a full-width result and a one-cycle update
//    pulse.
//
// Parameters:
//    DATA_W     sample width in bits
//    BUF_BIT_W  log2(window length). Must be >= 5 so the downstream sqrt
//               stage (~18 cycles per result) keeps up at one sample per
//               cycle.
//    SIGNED_IN  1: din_i is two's complement, 0: din_i is unsigned
//
// Ports:
//    clk            system clock, rising edge
//    rst_n          asynchronous active-low reset
//    clr            synchronous clear; wins over din_valid_i
//    din_i          ADC sample
//    din_valid_i    din_i valid this cycle
//    dout_o         window result (sum of squares, or mean square, see below)
//    dout_update_o  one-cycle pulse; dout_o is new this cycle
//    sample_cnt_o   samples accepted in the current window (0..N-1)
//
// Build option:
//    SUM_SQ_MEAN_EN  When defined, dout_o is the mean square, computed as
//                    (sum >> BUF_BIT_W) with truncation. When undefined,
//                    dout_o is the raw sum of squares. Ports and timing are
//                    the same in both builds.
//
// Timing:
//    The last sample of a window is valid in cycle t.
//    Stage 1 registers its square at the end of t.
//    Stage 2 closes the window at the end of t+1.
//    dout_update_o is high during cycle t+2.
//-----------------------------------------------------------------------------
module sum_sq_accumulator #(
   parameter int DATA_W    = 16,
   parameter int BUF_BIT_W = 8,
   parameter int SIGNED_IN = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic [DATA_W-1:0]             din_i,
   input  logic                          din_valid_i,
   output logic [2*DATA_W+BUF_BIT_W-1:0] dout_o,
   output logic                          dout_update_o,
   output logic [BUF_BIT_W-1:0]          sample_cnt_o
);

   localparam int SQ_W  = 2*DATA_W;
   localparam int ACC_W = 2*DATA_W + BUF_BIT_W;

   //--------------------------------------------------------------------------
   // Square
   //--------------------------------------------------------------------------
   // The operand is widened to 2*DATA_W bits first: sign-extended for signed
   // input, zero-extended for unsigned input. The low 2*DATA_W bits of the
   // product then equal the true square. This holds because the square is
   // non-negative and always fits in 2*DATA_W bits.
   logic [SQ_W-1:0] din_ext;
   logic [SQ_W-1:0] sq_prod;

   generate
      if (SIGNED_IN != 0) begin : g_signed_ext
         assign din_ext = {{DATA_W{din_i[DATA_W-1]}}, din_i};
      end else begin : g_unsigned_ext
         assign din_ext = {{DATA_W{1'b0}}, din_i};
      end
   endgenerate

   assign sq_prod = din_ext * din_ext;

   //--------------------------------------------------------------------------
   // State
   //--------------------------------------------------------------------------
   logic [BUF_BIT_W-1:0] sample_cnt_reg, sample_cnt_next;
   logic [SQ_W-1:0]      sq_reg,         sq_next;
   logic                 sq_vld_reg,     sq_vld_next;
   logic                 last_reg,       last_next;
   logic [ACC_W-1:0]     acc_reg,        acc_next;
   logic [ACC_W-1:0]     dout_reg,       dout_next;
   logic                 update_reg,     update_next;

   // Running sum including the square currently in stage 2.
   logic [ACC_W-1:0]     sum_next;
   logic [ACC_W-1:0]     result_next;

   assign sum_next = acc_reg + {{BUF_BIT_W{1'b0}}, sq_reg};

`ifdef SUM_SQ_MEAN_EN
   // Mean square: a truncating divide by N. The upper bits fill with zeros.
   assign result_next = sum_next >> BUF_BIT_W;
`else
   assign result_next = sum_next;
`endif

   //--------------------------------------------------------------------------
   // Stage 1: square the sample, count it, and tag the window's last sample
   //--------------------------------------------------------------------------
   always_comb begin
      sample_cnt_next = sample_cnt_reg;
      sq_next         = sq_reg;
      sq_vld_next     = 1'b0;
      last_next       = 1'b0;

      if (clr) begin
         sample_cnt_next = '0;
         sq_next         = '0;
      end else if (din_valid_i) begin
         sq_next         = sq_prod;
         sq_vld_next     = 1'b1;
         // The sample that wraps the counter from N-1 to 0 closes the window.
         last_next       = (sample_cnt_reg == {BUF_BIT_W{1'b1}});
         sample_cnt_next = sample_cnt_reg + 1'b1;
      end
   end

   //--------------------------------------------------------------------------
   // Stage 2: accumulate, or close the window
   //--------------------------------------------------------------------------
   always_comb begin
      acc_next    = acc_reg;
      dout_next   = dout_reg;
      update_next = 1'b0;

      if (clr) begin
         acc_next  = '0;
         dout_next = '0;
      end else if (sq_vld_reg) begin
         if (last_reg) begin
            dout_next   = result_next;
            // Restart from zero rather than from the stale sum. This way the
            // first square of the next window (in stage 2 on the next cycle)
            // starts a clean sum.
            acc_next    = '0;
            update_next = 1'b1;
         end else begin
            acc_next    = sum_next;
         end
      end
   end

   //--------------------------------------------------------------------------
   // Registers
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt_reg <= '0;
         sq_reg         <= '0;
         sq_vld_reg     <= 1'b0;
         last_reg       <= 1'b0;
         acc_reg        <= '0;
         dout_reg       <= '0;
         update_reg     <= 1'b0;
      end else begin
         sample_cnt_reg <= sample_cnt_next;
         sq_reg         <= sq_next;
         sq_vld_reg     <= sq_vld_next;
         last_reg       <= last_next;
         acc_reg        <= acc_next;
         dout_reg       <= dout_next;
         update_reg     <= update_next;
      end
   end

   assign dout_o        = dout_reg;
   assign dout_update_o = update_reg;
   assign sample_cnt_o  = sample_cnt_reg;

endmodule

// File: tb/tb_sum_sq_accumulator.sv
`timescale 1ns/1ps
module tb_sum_sq_accumulator;

   localparam int DATA_W    = 16;
   localparam int BUF_BIT_W = 5;
   localparam int N         = 32;
   localparam int ACC_W     = 2*DATA_W + BUF_BIT_W;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 clr;
   logic [DATA_W-1:0]    din;
   logic                 din_valid;
   logic [ACC_W-1:0]     dout;
   logic                 dout_update;
   logic [BUF_BIT_W-1:0] sample_cnt;

   sum_sq_accumulator #(
      .DATA_W   (DATA_W),
      .BUF_BIT_W(BUF_BIT_W),
      .SIGNED_IN(1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .din_i        (din),
      .din_valid_i  (din_valid),
      .dout_o       (dout),
      .dout_update_o(dout_update),
      .sample_cnt_o (sample_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Expected-behaviour tracker. Window results come from the hand-computed
   // table; this only tracks when each result appears.
   int               m_cnt;
   bit               m_fire1;
   logic [ACC_W-1:0] m_val1;
   bit               m_upd;
   logic [ACC_W-1:0] m_dout;
   logic [ACC_W-1:0] cur_exp;

   typedef struct {
      logic signed [15:0] a;      // value of the first n_a samples (or even samples)
      logic signed [15:0] b;      // value of the remaining samples (or odd samples)
      int                 n_a;
      bit                 alt;    // alternate a/b per sample
      bit                 gap;    // one idle cycle after every valid sample
      logic [ACC_W-1:0]   raw;    // hand-computed sum of squares
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [ACC_W-1:0] scale(input logic [ACC_W-1:0] raw);
`ifdef SUM_SQ_MEAN_EN
      return raw >> BUF_BIT_W;
`else
      return raw;
`endif
   endfunction

   task automatic model_reset();
      m_cnt   = 0;
      m_fire1 = 1'b0;
      m_val1  = '0;
      m_upd   = 1'b0;
      m_dout  = '0;
   endtask

   // Advance one clock, update expectations from the inputs applied, check outputs.
   task automatic tick();
      bit fire_n;
      if (clr) begin
         model_reset();
      end else begin
         m_upd = m_fire1;
         if (m_fire1) m_dout = m_val1;
         fire_n = din_valid && (m_cnt == N-1);
         if (din_valid) m_cnt = (m_cnt + 1) % N;
         m_fire1 = fire_n;
         m_val1  = cur_exp;
      end
      @(posedge clk);
      #1;
      chk("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
      chk("dout_update", 64'(dout_update), 64'(m_upd));
      chk("dout", 64'(dout), 64'(m_dout));
      if (dout_update) $display("pulse: dout=%0d (expected %0d)", dout, m_dout);
   endtask

   initial begin
      vecs[0] = '{a:  16'sd100,    b:  16'sd100,    n_a: 32, alt: 0, gap: 0, raw: 37'd320000};
      vecs[1] = '{a: -16'sd32768,  b: -16'sd32768,  n_a: 32, alt: 0, gap: 0, raw: 37'd34359738368};
      vecs[2] = '{a:  16'sd0,      b:  16'sd0,      n_a: 32, alt: 0, gap: 0, raw: 37'd0};
      vecs[3] = '{a:  16'sd1000,   b: -16'sd1000,   n_a: 0,  alt: 1, gap: 1, raw: 37'd32000000};
      vecs[4] = '{a:  16'sd3,      b:  16'sd4,      n_a: 31, alt: 0, gap: 0, raw: 37'd295};
      vecs[5] = '{a:  16'sd32767,  b:  16'sd32767,  n_a: 32, alt: 0, gap: 0, raw: 37'd34357641248};
      vecs[6] = '{a:  16'sd1,      b: -16'sd1,      n_a: 16, alt: 0, gap: 0, raw: 37'd32};

      rst_n = 1'b0; clr = 1'b0; din = '0; din_valid = 1'b0; cur_exp = '0;
      model_reset();
      #2;
      chk("reset dout", 64'(dout), 64'd0);
      chk("reset dout_update", 64'(dout_update), 64'd0);
      chk("reset sample_cnt", 64'(sample_cnt), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // Table: back-to-back windows, where the first sample of the next window
      // immediately follows the last sample of the previous one.
      for (int w = 0; w < 7; w++) begin
         cur_exp = scale(vecs[w].raw);
         $display("window %0d: expect dout=%0d", w, cur_exp);
         for (int i = 0; i < N; i++) begin
            if (vecs[w].alt) din = (i % 2 == 0) ? vecs[w].a : vecs[w].b;
            else             din = (i < vecs[w].n_a) ? vecs[w].a : vecs[w].b;
            din_valid = 1'b1;
            tick();
            if (vecs[w].gap) begin
               din_valid = 1'b0;
               din = 16'h7fff;   // junk while invalid must not count
               tick();
            end
         end
      end
      din_valid = 1'b0;
      tick(); tick(); tick();

      // Partial window discarded by clr. The clr cycle also carries valid.
      $display("clr sequence: 20 x 50, clr, 32 x 10");
      din = 16'd50;
      for (int i = 0; i < 20; i++) begin din_valid = 1'b1; tick(); end
      clr = 1'b1; din_valid = 1'b1;
      tick();
      clr = 1'b0; din_valid = 1'b0;
      tick();
      chk("clr dout zero", 64'(dout), 64'd0);
      cur_exp = scale(37'd3200);
      din = 16'd10;
      for (int i = 0; i < N; i++) begin din_valid = 1'b1; tick(); end
      din_valid = 1'b0;
      tick(); tick(); tick();

      // Asynchronous reset during the 10th sample.
      $display("async reset sequence: 9 x 7, reset, 32 x 7");
      din = 16'd7;
      for (int i = 0; i < 9; i++) begin din_valid = 1'b1; tick(); end
      din_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async rst dout", 64'(dout), 64'd0);
      chk("async rst dout_update", 64'(dout_update), 64'd0);
      chk("async rst sample_cnt", 64'(sample_cnt), 64'd0);
      model_reset();
      din_valid = 1'b0;
      #2 rst_n = 1'b1;
      cur_exp = scale(37'd1568);
      for (int i = 0; i < N; i++) begin din_valid = 1'b1; tick(); end
      din_valid = 1'b0;
      tick(); tick(); tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
